// File: rtl/clock_adjust_ctrl.sv
// MM:SS time-keeping controller: run/pause/adjust sequencing, BCD digits and blink masks.
// Optional build macro CLOCK_ADJ_CARRY_EN: seconds wrap in ADJ_SEC also increments minutes.
module clock_adjust_ctrl #(
  parameter int MIN_MAX = 59
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick_1hz,
  input  logic       tick_2hz,
  input  logic       tick_4hz,
  input  logic       pause_btn,
  input  logic       adj,
  input  logic       sel,
  output logic [3:0] min_ten,
  output logic [3:0] min_one,
  output logic [3:0] sec_ten,
  output logic [3:0] sec_one,
  output logic [3:0] blank_mask,
  output logic [1:0] mode
);

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    PAUSED  = 2'd1,
    ADJ_MIN = 2'd2,
    ADJ_SEC = 2'd3
  } state_e;

  localparam logic [3:0] MAX_TEN = 4'(MIN_MAX / 10);
  localparam logic [3:0] MAX_ONE = 4'(MIN_MAX % 10);

  state_e     state_q, state_d;
  logic       paused_q, paused_d;
  logic       pause_q;
  logic       blink_q, blink_d;
  logic [3:0] mask_q, mask_d;
  logic [3:0] min_ten_q, min_ten_d, min_one_q, min_one_d;
  logic [3:0] sec_ten_q, sec_ten_d, sec_one_q, sec_one_d;
  logic       pause_rise;
  logic       sec_inc, sec_wrap, min_inc;

  assign pause_rise = pause_btn & ~pause_q;

  always_comb begin
    paused_d  = paused_q ^ (pause_rise & ~adj);
    state_d   = state_q;
    blink_d   = 1'b0;
    mask_d    = 4'b0000;
    sec_one_d = sec_one_q;
    sec_ten_d = sec_ten_q;
    min_one_d = min_one_q;
    min_ten_d = min_ten_q;
    sec_wrap  = 1'b0;

    if (adj) state_d = sel ? ADJ_SEC : ADJ_MIN;
    else     state_d = paused_d ? PAUSED : RUN;

    // Phase only advances while staying in adjust, so entry always starts unblanked.
    if (state_q[1] && state_d[1]) blink_d = blink_q ^ tick_4hz;
    if (blink_d) mask_d = (state_d == ADJ_MIN) ? 4'b1100 : 4'b0011;

    sec_inc = ((state_q == RUN) && tick_1hz) || ((state_q == ADJ_SEC) && tick_2hz);
    if (sec_inc) begin
      if (sec_one_q >= 4'd9) begin
        sec_one_d = 4'd0;
        if (sec_ten_q >= 4'd5) begin
          sec_ten_d = 4'd0;
          sec_wrap  = 1'b1;
        end else begin
          sec_ten_d = sec_ten_q + 4'd1;
        end
      end else begin
        sec_one_d = sec_one_q + 4'd1;
      end
    end

`ifdef CLOCK_ADJ_CARRY_EN
    min_inc = ((state_q == RUN) && sec_wrap) || ((state_q == ADJ_MIN) && tick_2hz) ||
              ((state_q == ADJ_SEC) && sec_wrap);
`else
    min_inc = ((state_q == RUN) && sec_wrap) || ((state_q == ADJ_MIN) && tick_2hz);
`endif

    if (min_inc) begin
      if ((min_ten_q > MAX_TEN) || ((min_ten_q == MAX_TEN) && (min_one_q >= MAX_ONE))) begin
        min_ten_d = 4'd0;
        min_one_d = 4'd0;
      end else if (min_one_q >= 4'd9) begin
        min_one_d = 4'd0;
        min_ten_d = min_ten_q + 4'd1;
      end else begin
        min_one_d = min_one_q + 4'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= RUN;
      paused_q  <= 1'b0;
      pause_q   <= 1'b0;
      blink_q   <= 1'b0;
      mask_q    <= 4'b0000;
      min_ten_q <= 4'd0;
      min_one_q <= 4'd0;
      sec_ten_q <= 4'd0;
      sec_one_q <= 4'd0;
    end else begin
      state_q   <= state_d;
      paused_q  <= paused_d;
      pause_q   <= pause_btn;
      blink_q   <= blink_d;
      mask_q    <= mask_d;
      min_ten_q <= min_ten_d;
      min_one_q <= min_one_d;
      sec_ten_q <= sec_ten_d;
      sec_one_q <= sec_one_d;
    end
  end

  assign min_ten    = min_ten_q;
  assign min_one    = min_one_q;
  assign sec_ten    = sec_ten_q;
  assign sec_one    = sec_one_q;
  assign blank_mask = mask_q;
  assign mode       = state_q;

endmodule
